// File: rtl/fdtd_calc_hy.sv
// fdtd_calc_hy: streaming 1-D FDTD magnetic-field update, Hy_n[i] = chyh*Hy_old[i] + chyez*(Ez[i+1]-Ez[i]).
// Optional build macro FDTD_HY_SAT_EN: saturating product cut and final add instead of plain wrap.
module fdtd_calc_hy #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int CUT_LT          = 51,
  parameter int CUT_RT          = 21,
  parameter int CELL_CNT_WIDTH  = 10
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  input  logic [CELL_CNT_WIDTH-1:0]  num_cells,
  input  logic [FDTD_DATA_WIDTH-1:0] chyh,
  input  logic [FDTD_DATA_WIDTH-1:0] chyez,
  input  logic                       in_valid,
  input  logic [FDTD_DATA_WIDTH-1:0] Ez_i,
  input  logic [FDTD_DATA_WIDTH-1:0] Hy_old_i,
  output logic [FDTD_DATA_WIDTH-1:0] Hy_n_o,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int W  = FDTD_DATA_WIDTH;
  localparam int PW = 2 * FDTD_DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CELL_CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CELL_CNT_WIDTH-1:0] CNT_ONE  = CELL_CNT_WIDTH'(1);

`ifdef FDTD_HY_SAT_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  logic [1:0]                state;
  logic [CELL_CNT_WIDTH-1:0] cell_cnt;
  logic [CELL_CNT_WIDTH-1:0] idx;
  logic [CELL_CNT_WIDTH-1:0] idx_next;
  logic signed [W-1:0]       chyh_r;
  logic signed [W-1:0]       chyez_r;
  logic [W-1:0]              prev_ez;
  logic [W-1:0]              prev_hy;
  logic                      accept;
  logic                      flush;
  logic                      inject;

  logic                      s0_valid;
  logic                      s0_last;
  logic [W-1:0]              s0_ez_cur;
  logic [W-1:0]              s0_ez_next;
  logic [W-1:0]              s0_hy;

  logic                      s1_valid;
  logic                      s1_last;
  logic signed [W-1:0]       s1_diff;
  logic signed [W-1:0]       s1_hy;

  logic                      s2_valid;
  logic                      s2_last;
  logic signed [PW-1:0]      s2_prod_hy;
  logic signed [PW-1:0]      s2_prod_ez;

  logic [W-1:0]              cut_hy;
  logic [W-1:0]              cut_ez;
  logic [W-1:0]              hy_sum;
  logic                      unused_prod_bits;

  assign busy     = (state != ST_IDLE);
  assign accept   = (state == ST_RUN) && in_valid;
  assign flush    = (state == ST_FLUSH);
  // Sample 0 only primes "previous"; every later accept and the flush cycle each emit one cell.
  assign inject   = (accept && (idx != CNT_ZERO)) || flush;
  assign idx_next = idx + CNT_ONE;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      idx      <= CNT_ZERO;
      cell_cnt <= CNT_ZERO;
      chyh_r   <= '0;
      chyez_r  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cell_cnt <= num_cells;
            chyh_r   <= chyh;
            chyez_r  <= chyez;
            idx      <= CNT_ZERO;
            if (num_cells == CNT_ZERO) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            idx <= idx_next;
            if (idx_next == cell_cnt) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_valid && out_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      Hy_n_o    <= '0;
    end else begin
      s0_valid  <= inject;
      s0_last   <= flush;
      s1_valid  <= s0_valid;
      s1_last   <= s0_last;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      out_last  <= s2_valid && s2_last;
      if (s2_valid) begin
        Hy_n_o <= hy_sum;
      end
    end
  end

  // Flush pairs the last sample with a zero neighbour (PEC boundary beyond cell N-1).
  always_ff @(posedge CLK) begin
    if (accept) begin
      prev_ez <= Ez_i;
      prev_hy <= Hy_old_i;
    end
    if (inject) begin
      s0_ez_cur  <= prev_ez;
      s0_ez_next <= flush ? '0 : Ez_i;
      s0_hy      <= prev_hy;
    end
    s1_diff    <= s0_ez_next - s0_ez_cur;
    s1_hy      <= s0_hy;
    s2_prod_hy <= PW'(chyh_r) * PW'(s1_hy);
    s2_prod_ez <= PW'(chyez_r) * PW'(s1_diff);
  end

  always_comb begin
    cut_hy = {s2_prod_hy[PW-1], s2_prod_hy[CUT_LT:CUT_RT]};
    cut_ez = {s2_prod_ez[PW-1], s2_prod_ez[CUT_LT:CUT_RT]};
`ifdef FDTD_HY_SAT_EN
    if (!(&s2_prod_hy[PW-1:CUT_LT]) && (|s2_prod_hy[PW-1:CUT_LT])) begin
      cut_hy = s2_prod_hy[PW-1] ? SAT_MIN : SAT_MAX;
    end
    if (!(&s2_prod_ez[PW-1:CUT_LT]) && (|s2_prod_ez[PW-1:CUT_LT])) begin
      cut_ez = s2_prod_ez[PW-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_comb begin
    hy_sum = cut_hy + cut_ez;
`ifdef FDTD_HY_SAT_EN
    if ((cut_hy[W-1] == cut_ez[W-1]) && (hy_sum[W-1] != cut_hy[W-1])) begin
      hy_sum = cut_hy[W-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  assign unused_prod_bits = ^{s2_prod_hy[CUT_RT-1:0], s2_prod_ez[CUT_RT-1:0],
                              s2_prod_hy[PW-2:CUT_LT+1], s2_prod_ez[PW-2:CUT_LT+1]};

endmodule

// File: tb/tb_fdtd_calc_hy.sv
// tb_fdtd_calc_hy: directed and randomized sweeps of fdtd_calc_hy against an arithmetic reference model.
// Follows FDTD_HY_SAT_EN in the same way as the design.
module tb_fdtd_calc_hy;

  localparam logic [31:0] UNIT = 32'h0020_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start;
  logic [9:0]  num_cells;
  logic [31:0] chyh;
  logic [31:0] chyez;
  logic        in_valid;
  logic [31:0] Ez_i;
  logic [31:0] Hy_old_i;
  logic [31:0] Hy_n_o;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;

  fdtd_calc_hy dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .num_cells (num_cells),
    .chyh      (chyh),
    .chyez     (chyez),
    .in_valid  (in_valid),
    .Ez_i      (Ez_i),
    .Hy_old_i  (Hy_old_i),
    .Hy_n_o    (Hy_n_o),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] value;
    int          cycle;
    logic        last;
  } exp_t;

  exp_t        expQ[$];
  int          doneQ[$];
  logic [31:0] obsLog[$];
  logic [31:0] ezArr[64];
  logic [31:0] hyArr[64];
  int          gapArr[64];
  int          nCompared = 0;
  int          nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [31:0] cutRef(input longint p);
    longint q;
`ifdef FDTD_HY_SAT_EN
    if (p > 64'sd2251799813685247) return 32'h7FFF_FFFF;
    if (p < -64'sd2251799813685248) return 32'h8000_0000;
`endif
    q = p >>> 21;
    return {(p < 0), q[30:0]};
  endfunction

  function automatic logic [31:0] refHy(input logic [31:0] hyOld, input logic [31:0] ezCur,
                                        input logic [31:0] ezNext, input logic [31:0] c1,
                                        input logic [31:0] c2);
    int          diff;
    logic [31:0] tHy;
    logic [31:0] tEz;
    longint      s;
    diff = $signed(ezNext) - $signed(ezCur);
    tHy  = cutRef(longint'($signed(c1)) * longint'($signed(hyOld)));
    tEz  = cutRef(longint'($signed(c2)) * longint'(diff));
    s    = longint'($signed(tHy)) + longint'($signed(tEz));
`ifdef FDTD_HY_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Every output must match the head of the expectation queue in value, cycle and last flag.
  always @(negedge CLK) begin
    exp_t e;
    int   d;
    if (RST_N) begin
      if (out_valid) begin
        obsLog.push_back(Hy_n_o);
        if (expQ.size() == 0) begin
          checkOutput("stray_out_valid", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("hy_value", Hy_n_o, e.value);
          checkOutput("hy_cycle", cyc, e.cycle);
          checkOutput("out_last", out_last, e.last);
        end
      end else begin
        if (out_last) checkOutput("last_without_valid", out_last, 0);
        if (expQ.size() > 0 && expQ[0].cycle < cyc) begin
          e = expQ.pop_front();
          checkOutput("missing_out", cyc, e.cycle);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          checkOutput("stray_done", done, 0);
        end else begin
          d = doneQ.pop_front();
          checkOutput("done_cycle", cyc, d);
        end
      end else if (doneQ.size() > 0 && doneQ[0] < cyc) begin
        d = doneQ.pop_front();
        checkOutput("missing_done", cyc, d);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic [31:0] ch, input logic [31:0] cz, input bit extraValid);
    int acc[64];
    int ts;
    obsLog.delete();
    step();
    in_valid = 1'b1;
    Ez_i = $urandom;
    Hy_old_i = $urandom;
    start = 1'b0;
    step();
    in_valid = 1'b0;
    start = 1'b1;
    num_cells = n[9:0];
    chyh = ch;
    chyez = cz;
    ts = cyc + 1;
    if (n == 0) doneQ.push_back(ts);
    step();
    start = 1'b0;
    num_cells = $urandom;
    chyh = $urandom;
    chyez = $urandom;
    checkOutput("busy_after_start", busy, (n != 0));
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gapArr[k]; g++) begin
        in_valid = 1'b0;
        start = 1'b1;
        num_cells = $urandom;
        Ez_i = $urandom;
        step();
      end
      start = 1'b0;
      in_valid = 1'b1;
      Ez_i = ezArr[k];
      Hy_old_i = hyArr[k];
      acc[k] = cyc + 1;
      step();
      if (k >= 1) begin
        expQ.push_back('{refHy(hyArr[k-1], ezArr[k-1], ezArr[k], ch, cz), acc[k] + 3, 1'b0});
      end
    end
    if (n > 0) begin
      expQ.push_back('{refHy(hyArr[n-1], ezArr[n-1], 32'd0, ch, cz), acc[n-1] + 4, 1'b1});
      doneQ.push_back(acc[n-1] + 5);
    end
    if (extraValid) begin
      in_valid = 1'b1;
      Ez_i = $urandom;
      Hy_old_i = $urandom;
      step();
      step();
    end
    in_valid = 1'b0;
    for (int w = 0; w < 100 && (expQ.size() > 0 || doneQ.size() > 0); w++) step();
    if (expQ.size() > 0 || doneQ.size() > 0) begin
      checkOutput("sweep_timeout", expQ.size() + doneQ.size(), 0);
      expQ.delete();
      doneQ.delete();
    end
    step();
    checkOutput("busy_idle", busy, 0);
    step();
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [31:0] expected);
    if (idx < obsLog.size()) checkOutput(tag, obsLog[idx], expected);
    else checkOutput(tag, obsLog.size(), idx + 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] ch;
    logic [31:0] cz;
    RST_N = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    num_cells = '0;
    chyh = '0;
    chyez = '0;
    Ez_i = '0;
    Hy_old_i = '0;
    for (int k = 0; k < 64; k++) gapArr[k] = 0;
    repeat (3) step();
    checkOutput("rst_hy", Hy_n_o, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    RST_N = 1'b1;
    step();

    ezArr[0] = 10; ezArr[1] = 30; ezArr[2] = 60;
    hyArr[0] = 0;  hyArr[1] = 0;  hyArr[2] = 0;
    applyStimulus(3, UNIT, UNIT, 1'b1);
    checkOutput("t1_count", obsLog.size(), 3);
    checkLog("t1_cell0", 0, 32'd20);
    checkLog("t1_cell1", 1, 32'd30);
    checkLog("t1_cell2", 2, 32'hFFFF_FFC4);

    ezArr[0] = $urandom; ezArr[1] = $urandom;
    hyArr[0] = 32'd5; hyArr[1] = 32'hFFFF_FFF9;
    gapArr[0] = 2; gapArr[1] = 2;
    applyStimulus(2, UNIT, 32'd0, 1'b0);
    gapArr[0] = 0; gapArr[1] = 0;
    checkLog("t2_cell0", 0, 32'd5);
    checkLog("t2_cell1", 1, 32'hFFFF_FFF9);

    ezArr[0] = $urandom;
    hyArr[0] = 32'h4000_0000;
    applyStimulus(1, 32'h0040_0000, 32'd0, 1'b0);
`ifdef FDTD_HY_SAT_EN
    checkLog("t3_cut_overflow", 0, 32'h7FFF_FFFF);
`else
    checkLog("t3_cut_overflow", 0, 32'h0000_0000);
`endif

    step();
    start = 1'b1;
    num_cells = 10'd8;
    chyh = UNIT;
    chyez = UNIT;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      Ez_i = $urandom;
      Hy_old_i = $urandom;
      step();
    end
    RST_N = 1'b0;
    in_valid = 1'b0;
    step();
    checkOutput("midrst_hy", Hy_n_o, 0);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_last", out_last, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    RST_N = 1'b1;
    step();
    ezArr[0] = 32'd1; ezArr[1] = 32'd2;
    hyArr[0] = 32'd0; hyArr[1] = 32'd0;
    applyStimulus(2, UNIT, UNIT, 1'b0);
    checkOutput("fresh_count", obsLog.size(), 2);
    checkLog("fresh_cell0", 0, 32'd1);
    checkLog("fresh_cell1", 1, 32'hFFFF_FFFE);

    applyStimulus(0, UNIT, UNIT, 1'b0);
    checkOutput("n0_count", obsLog.size(), 0);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 12);
      if (r == 0) n = 1;
      if (r == 1) n = 40;
      for (int k = 0; k < n; k++) begin
        ezArr[k] = $urandom;
        hyArr[k] = $urandom;
        gapArr[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (r % 4 == 1) begin
          ezArr[k] = $urandom_range(0, 2000) - 1000;
          hyArr[k] = $urandom_range(0, 2000) - 1000;
        end
      end
      if (r % 2 == 1) begin
        ch = $urandom_range(0, 32'h0080_0000) - 32'h0040_0000;
        cz = $urandom_range(0, 32'h0080_0000) - 32'h0040_0000;
      end else begin
        ch = $urandom;
        cz = $urandom;
      end
      applyStimulus(n, ch, cz, (r % 3 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
